vga_timing_gen: RTL and testbench

Video timing generator for the 800x480 LCD/VGA output, clocked on the 32 MHz pixel clock domain.
- Produces horizontal/vertical sync, data-enable, current pixel coordinates and a one-cycle frame-start pulse.
- Includes a built-in colour-bar/border test pattern so the display path can be brought up before the SDRAM frame-buffer reader exists.
- Sits directly downstream of the pixel clock/reset generation in Top, and upstream of the video DAC/HDMI pins in hws_ifm.

---
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 800x480 panel, with a built-in colour-bar/border test pattern.
// Every output is registered and lags the raster counters by exactly one pixel clock.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  input  logic                     pattern_en,
  output logic                     vga_hs,
  output logic                     vga_vs,
  output logic                     vga_de,
  output logic [$clog2(HDISP)-1:0] vga_x,
  output logic [$clog2(VDISP)-1:0] vga_y,
  output logic                     frame_start,
  output logic [7:0]               vga_r,
  output logic [7:0]               vga_g,
  output logic [7:0]               vga_b
);
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);
  localparam int BAR_W  = HDISP / 8;

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT_E  = HW'(HDISP);
  localparam logic [HW-1:0] H_SYNC_S = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HDISP + HFP + HPULSE);
  localparam logic [HW-1:0] H_RIGHT  = HW'(HDISP - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT_E  = VW'(VDISP);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VDISP + VFP + VPULSE);
  localparam logic [VW-1:0] V_BOTTOM = VW'(VDISP - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [2:0]    bar;
  logic [2:0]    bar_rgb;
  logic          border;

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Bar index is the number of bar boundaries the column has passed.
  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++) begin
      if (int'(hcnt_q) >= i * BAR_W) bar = 3'(i);
    end
    unique case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    de_d   = (hcnt_q < H_ACT_E) && (vcnt_q < V_ACT_E);
    hs_d   = !((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E));
    vs_d   = !((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E));
    fs_d   = (hcnt_q == '0) && (vcnt_q == '0);
    x_d    = de_d ? hcnt_q[XW-1:0] : '0;
    y_d    = de_d ? vcnt_q[YW-1:0] : '0;
    border = (hcnt_q == '0) || (hcnt_q == H_RIGHT) || (vcnt_q == '0) || (vcnt_q == V_BOTTOM);
    rgb_d  = '0;
    if (de_d && pattern_en) begin
      rgb_d = border ? 24'hFF_FF_FF
                     : {{8{bar_rgb[2]}}, {8{bar_rgb[1]}}, {8{bar_rgb[0]}}};
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      rgb_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
      x_q    <= x_d;
      y_q    <= y_d;
      rgb_q  <= rgb_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-width lines with a shortened frame height so whole frames fit in a short run.
// Random pattern_en against an arithmetic raster model, plus line/frame event-interval and async-reset checks.
module tb_vga_timing_gen;
  localparam int HDISP = 800, HFP = 40, HPULSE = 48, HBP = 40;
  localparam int VDISP = 20, VFP = 3, VPULSE = 3, VBP = 4;
  localparam int HT = HDISP + HFP + HPULSE + HBP;
  localparam int VT = VDISP + VFP + VPULSE + VBP;
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = 4 + XW + YW + 24;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  localparam logic [BW-1:0] RST_VAL = {1'b1, 1'b1, 1'b0, 1'b0, {(XW+YW+24){1'b0}}};

  logic          pixel_clk, pixel_rst, pattern_en;
  logic          vga_hs, vga_vs, vga_de, frame_start;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [7:0]    vga_r, vga_g, vga_b;

  int   n_chk = 0, n_err = 0;
  int   pos;
  logic pe_s;
  logic prev_de, prev_hs, prev_vs;
  int   de_rise_pos, hs_fall_pos, vs_fall_pos, last_fs_pos;

  vga_timing_gen #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .pattern_en(pattern_en),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_x(vga_x), .vga_y(vga_y), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] observed();
    return {vga_hs, vga_vs, vga_de, frame_start, vga_x, vga_y, vga_r, vga_g, vga_b};
  endfunction

  // Expected outputs for raster position p (clocks since the counters restarted).
  function automatic logic [BW-1:0] model(input int p, input logic pe);
    int h, v;
    logic de, hs, vs, fs;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [23:0] rgb;
    h   = p % HT;
    v   = (p / HT) % VT;
    de  = (h < HDISP) && (v < VDISP);
    hs  = !(h >= HDISP + HFP && h < HDISP + HFP + HPULSE);
    vs  = !(v >= VDISP + VFP && v < VDISP + VFP + VPULSE);
    fs  = (h == 0) && (v == 0);
    x   = de ? XW'(h) : '0;
    y   = de ? YW'(v) : '0;
    if (!de || !pe) rgb = 24'h0;
    else if (h == 0 || h == HDISP - 1 || v == 0 || v == VDISP - 1) rgb = 24'hFFFFFF;
    else rgb = BARS[h / (HDISP / 8)];
    return {hs, vs, de, fs, x, y, rgb};
  endfunction

  task automatic clear_trackers();
    pos = -1;
    prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    de_rise_pos = -1; hs_fall_pos = -1; vs_fall_pos = -1; last_fs_pos = -1;
  endtask

  // Called at a negedge: drive pattern_en, take one edge, then check at the following negedge.
  task automatic step();
    int np, nv, h, v;
    np = pos + 1;
    nv = (np / HT) % VT;
    if (nv == 5) pattern_en = 1'b1;
    else if (nv == 7) pattern_en = 1'b0;
    else if ($urandom_range(0, 3) == 0) pattern_en = ~pattern_en;
    pe_s = pattern_en;
    @(posedge pixel_clk);
    pos = np;
    @(negedge pixel_clk);
    h = pos % HT;
    v = (pos / HT) % VT;
    chk($sformatf("cyc%0d", pos), 64'(observed()), 64'(model(pos, pe_s)));

    if (v == 5) begin
      case (h)
        50:  chk("pat_x50",  64'({vga_r, vga_g, vga_b}), 64'(24'hFFFFFF));
        150: chk("pat_x150", 64'({vga_r, vga_g, vga_b}), 64'(24'hFFFF00));
        450: chk("pat_x450", 64'({vga_r, vga_g, vga_b}), 64'(24'hFF00FF));
        750: chk("pat_x750", 64'({vga_r, vga_g, vga_b}), 64'(24'h000000));
        799: chk("pat_x799", 64'({vga_r, vga_g, vga_b}), 64'(24'hFFFFFF));
        820: chk("blank_fp", 64'({vga_x, vga_y, vga_r, vga_g, vga_b}), 64'(0));
        default: ;
      endcase
    end
    if (v == 7 && h == 150) chk("pat_off", 64'({vga_r, vga_g, vga_b}), 64'(0));

    if (frame_start) begin
      if (last_fs_pos < 0) chk("fs_first", 64'(pos), 64'(0));
      else chk("fs_period", 64'(pos - last_fs_pos), 64'(HT * VT));
      last_fs_pos = pos;
    end
    if (vga_de && !prev_de) begin
      de_rise_pos = pos;
      chk("de_rise_x", 64'(vga_x), 64'(0));
    end
    if (!vga_de && prev_de) chk("de_len", 64'(pos - de_rise_pos), 64'(HDISP));
    if (!vga_hs && prev_hs) begin
      if (hs_fall_pos >= 0) chk("hs_period", 64'(pos - hs_fall_pos), 64'(HT));
      if (de_rise_pos >= 0 && pos - de_rise_pos < HT)
        chk("hs_after_de", 64'(pos - de_rise_pos), 64'(HDISP + HFP));
      hs_fall_pos = pos;
    end
    if (vga_hs && !prev_hs) chk("hs_len", 64'(pos - hs_fall_pos), 64'(HPULSE));
    if (!vga_vs && prev_vs) begin
      if (last_fs_pos >= 0) chk("vs_fall_at", 64'(pos - last_fs_pos), 64'((VDISP + VFP) * HT));
      vs_fall_pos = pos;
    end
    if (vga_vs && !prev_vs) chk("vs_len", 64'(pos - vs_fall_pos), 64'(VPULSE * HT));
    prev_de = vga_de; prev_hs = vga_hs; prev_vs = vga_vs;
  endtask

  initial begin
    pixel_rst  = 1'b1;
    pattern_en = 1'b0;
    pe_s       = 1'b0;
    clear_trackers();
    repeat (3) @(negedge pixel_clk);
    chk("rst_init", 64'(observed()), 64'(RST_VAL));
    pixel_rst = 1'b0;

    // Run one full frame, then stop on line 10, pixel 300 of the next.
    repeat (HT * VT + 10 * HT + 301) step();
    chk("pre_rst_xy", 64'({vga_x, vga_y}), 64'({XW'(300), YW'(10)}));

    #2 pixel_rst = 1'b1;
    #1 chk("rst_async", 64'(observed()), 64'(RST_VAL));
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("rst_hold", 64'(observed()), 64'(RST_VAL));
    pixel_rst = 1'b0;
    clear_trackers();

    repeat (2 * HT + 10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
